stream_demux1to2_32bit: RTL and testbench
=========================================

Name: stream_demux1to2_32bit

Overview:
- Inverse of the 2:1 32-bit datapath mux.
- Steers one valid/ready 32-bit input stream to one of two output streams, selected per transfer by in_sel.
- Each output lane buffers in a small FIFO, so a stalled consumer does not block the other lane's traffic already queued.
- Sits between a single producer (e.g. a result bus) and two consumers (e.g. register-file writeback vs. memory store path).

Parameters:
- DATA_W, 32, width of payload.
- DEPTH, 2, entries per lane FIFO; power of two, ≥2.
- CNT_W, 16, width of per-lane transfer counters.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  lane addressed by in_sel can accept.
- in_data  input  DATA_W  payload.
- in_sel  input  1  0 → lane 0, 1 → lane 1; sampled with in_data.
- out0_valid  output  1  lane 0 head valid.
- out0_ready  input  1  lane 0 consumer accepts.
- out0_data  output  DATA_W  lane 0 head word.
- out1_valid  output  1  lane 1 head valid.
- out1_ready  input  1  lane 1 consumer accepts.
- out1_data  output  DATA_W  lane 1 head word.
- cnt0  output  CNT_W  words delivered on lane 0.
- cnt1  output  CNT_W  words delivered on lane 1.

Behaviour:
- Reset (async assert, sync deassert by caller):
  - all FIFO pointers and occupancies clear.
  - out0_valid = out1_valid = 0; out0_data = out1_data = 0; cnt0 = cnt1 = 0.
  - in_ready = 1 after reset.
  - Reset mid-operation discards all queued words; no partial state survives.
- Handshake and push:
  - in_ready = !full[in_sel], combinational from in_sel and registered occupancy only; never depends on in_valid.
  - Push occurs when in_valid && in_ready, into lane in_sel, at that clk edge.
  - Producer holds in_data and in_sel stable while in_valid && !in_ready; no requirement if in_valid = 0.
- Latency:
  - A pushed word appears at outK_valid/outK_data on the cycle after the push edge.
  - No combinational bypass, including into an empty lane.
- Pop and output:
  - Pop occurs when outK_valid && outK_ready; outK_data then advances to the next entry on the following cycle.
  - When a lane is empty: outK_valid = 0 and outK_data = 0.
- Lane independence:
  - A full lane blocks only transfers addressed to it.
  - in_ready toggles with in_sel in the same cycle.
- Simultaneous push and pop, same lane:
  - Not full: both take effect; occupancy unchanged.
  - Full: push is refused (in_ready = 0 that cycle), pop proceeds; there is no pass-through when full.
  - Empty: only the push is possible.
- Ordering: FIFO order within a lane. No ordering relation between lanes.
- Pointers: log2(DEPTH) bits, wrapping modulo DEPTH. Occupancy is log2(DEPTH)+1 bits, range 0..DEPTH.
- Counters:
  - cntK increments by 1 on each pop of lane K.
  - Wrap from 2^CNT_W−1 to 0 with no saturation or flag.
- Outputs come from registered state and head selection, with no input-to-output combinational path except in_sel → in_ready.

Decomposition:
- Shared package holds:
  - DATA_W default.
  - lane index constants LANE0 = 1'b0, LANE1 = 1'b1.
  - valid/ready field widths.
- One sub-module, lane_fifo: synchronous FIFO with DEPTH entries.
  - Interface: push/pop, full/empty, head data, async active-high rst.
  - Instantiated twice.
- Top level contains push steering, in_ready mux and the two counters.

Test Plan:
- Reset then idle: all valids 0, data 0, counts 0, in_ready = 1 for in_sel = 0 and 1.
- Push 32'h00000001 sel=0, out0_ready=1:
  - out0_valid = 1 with data 00000001 exactly one cycle later; out1_valid stays 0.
  - cnt0 = 1 after the pop.
- Backpressure lane 1: out1_ready = 0; push A1, A2, A3 with sel=1.
  - A1 and A2 accepted; in_ready = 0 for A3 while in_sel = 1.
  - With in_sel switched to 0, in_ready = 1 and word 3C3C3C3C is delivered on lane 0.
  - Release out1_ready: A1 then A2 emerge in order, then A3.
- Full lane 0, push and pop in the same cycle:
  - Push refused; pop delivers the head; push accepted on the next cycle.
  - Occupancy returns to 2.
- Counter wrap with CNT_W = 4: 17 pops on lane 0 give cnt0 = 1.
- Async reset asserted between clock edges while both lanes hold data:
  - Valids drop to 0 immediately, before the next edge; counts are 0.
  - First push after release appears with latency 1.

Source files
------------

// File: rtl/stream_demux1to2_32bit_pkg.sv
// Shared constants for the 1:2 stream demux: default payload width,
// lane index encodings and handshake field widths.
package stream_demux1to2_32bit_pkg;

    localparam int DATA_W_DEF = 32;

    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;

    localparam int VLD_W = 1;
    localparam int RDY_W = 1;

endpackage

// File: rtl/stream_demux1to2_32bit_lane_fifo.sv
// Per-lane synchronous FIFO with registered head; an empty FIFO presents
// zero on its head so the lane output is clean without a bypass path.
module stream_demux1to2_32bit_lane_fifo
    import stream_demux1to2_32bit_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  occ;
    logic              do_push;
    logic              do_pop;

    // A full FIFO refuses the push even when it is popped in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (occ == OCC_W'(DEPTH));
    assign empty = (occ == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/stream_demux1to2_32bit.sv
// 1:2 valid/ready demux: steers each input word to lane in_sel, buffers it
// in that lane's FIFO, and counts words delivered per lane.
module stream_demux1to2_32bit
    import stream_demux1to2_32bit_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sel,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [DATA_W-1:0] out0_data,
    output logic              out1_valid,
    input  logic              out1_ready,
    output logic [DATA_W-1:0] out1_data,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
);

    logic full0;
    logic full1;
    logic empty0;
    logic empty1;
    logic push0;
    logic push1;
    logic pop0;
    logic pop1;

    // Ready reflects only the addressed lane, so a full lane never stalls the other.
    assign in_ready = (in_sel == LANE1) ? !full1 : !full0;

    assign push0 = in_valid && in_ready && (in_sel == LANE0);
    assign push1 = in_valid && in_ready && (in_sel == LANE1);

    assign out0_valid = !empty0;
    assign out1_valid = !empty1;
    assign pop0       = out0_valid && out0_ready;
    assign pop1       = out1_valid && out1_ready;

    stream_demux1to2_32bit_lane_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_lane0 (
        .clk       (clk),
        .rst       (rst),
        .push      (push0),
        .push_data (in_data),
        .pop       (pop0),
        .full      (full0),
        .empty     (empty0),
        .head      (out0_data)
    );

    stream_demux1to2_32bit_lane_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_lane1 (
        .clk       (clk),
        .rst       (rst),
        .push      (push1),
        .push_data (in_data),
        .pop       (pop1),
        .full      (full1),
        .empty     (empty1),
        .head      (out1_data)
    );

    // Delivery counters wrap silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (pop0) cnt0 <= cnt0 + CNT_W'(1);
            if (pop1) cnt1 <= cnt1 + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_stream_demux1to2_32bit.sv
// Bench for the 1:2 stream demux: a vector table with explicit expectations
// plus per-lane scoreboard queues, and directed reset / counter-wrap sequences.
module tb_stream_demux1to2_32bit;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 2;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_sel;
    logic              out0_valid;
    logic              out0_ready;
    logic [DATA_W-1:0] out0_data;
    logic              out1_valid;
    logic              out1_ready;
    logic [DATA_W-1:0] out1_data;
    logic [CNT_W-1:0]  cnt0;
    logic [CNT_W-1:0]  cnt1;

    stream_demux1to2_32bit #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              iv;
        logic              sel;
        logic [DATA_W-1:0] data;
        logic              r0;
        logic              r1;
        logic              e_rdy;
        logic              e_v0;
        logic [DATA_W-1:0] e_d0;
        logic              e_v1;
        logic [DATA_W-1:0] e_d1;
        logic [CNT_W-1:0]  e_c0;
        logic [CNT_W-1:0]  e_c1;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    logic [DATA_W-1:0] q0[$];
    logic [DATA_W-1:0] q1[$];
    logic [CNT_W-1:0]  mc0 = '0;
    logic [CNT_W-1:0]  mc1 = '0;

    vec_t tbl[21];

    function automatic vec_t mk(input logic iv, input logic sel, input logic [31:0] data,
                                input logic r0, input logic r1, input logic e_rdy,
                                input logic e_v0, input logic [31:0] e_d0,
                                input logic e_v1, input logic [31:0] e_d1,
                                input int e_c0, input int e_c1);
        vec_t v;
        v.iv = iv; v.sel = sel; v.data = data; v.r0 = r0; v.r1 = r1;
        v.e_rdy = e_rdy; v.e_v0 = e_v0; v.e_d0 = e_d0; v.e_v1 = e_v1; v.e_d1 = e_d1;
        v.e_c0 = CNT_W'(e_c0); v.e_c1 = CNT_W'(e_c1);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock cycle: drive, check against model (and table if asked), advance model.
    task automatic run(input vec_t v, input bit use_exp, input string tag);
        logic              m_rdy;
        logic [DATA_W-1:0] m_d0;
        logic [DATA_W-1:0] m_d1;
        @(negedge clk);
        in_valid   = v.iv;
        in_sel     = v.sel;
        in_data    = v.data;
        out0_ready = v.r0;
        out1_ready = v.r1;
        #1;
        m_rdy = v.sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
        m_d0  = (q0.size() != 0) ? q0[0] : '0;
        m_d1  = (q1.size() != 0) ? q1[0] : '0;
        chk({tag, " sb in_ready"},   32'(in_ready),   32'(m_rdy));
        chk({tag, " sb out0_valid"}, 32'(out0_valid), 32'(q0.size() != 0));
        chk({tag, " sb out0_data"},  out0_data,       m_d0);
        chk({tag, " sb out1_valid"}, 32'(out1_valid), 32'(q1.size() != 0));
        chk({tag, " sb out1_data"},  out1_data,       m_d1);
        chk({tag, " sb cnt0"},       32'(cnt0),       32'(mc0));
        chk({tag, " sb cnt1"},       32'(cnt1),       32'(mc1));
        if (use_exp) begin
            chk({tag, " in_ready"},   32'(in_ready),   32'(v.e_rdy));
            chk({tag, " out0_valid"}, 32'(out0_valid), 32'(v.e_v0));
            chk({tag, " out0_data"},  out0_data,       v.e_d0);
            chk({tag, " out1_valid"}, 32'(out1_valid), 32'(v.e_v1));
            chk({tag, " out1_data"},  out1_data,       v.e_d1);
            chk({tag, " cnt0"},       32'(cnt0),       32'(v.e_c0));
            chk({tag, " cnt1"},       32'(cnt1),       32'(v.e_c1));
        end
        if (q0.size() != 0 && v.r0) begin
            void'(q0.pop_front());
            mc0++;
        end
        if (q1.size() != 0 && v.r1) begin
            void'(q1.pop_front());
            mc1++;
        end
        if (v.iv && m_rdy) begin
            if (v.sel) q1.push_back(v.data);
            else       q0.push_back(v.data);
        end
        @(posedge clk);
    endtask

    // Reset asserted between edges; outputs must clear before the next edge.
    task automatic async_reset(input string tag);
        @(negedge clk);
        in_valid   = 1'b0;
        in_sel     = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk({tag, " rst out0_valid"}, 32'(out0_valid), 32'd0);
        chk({tag, " rst out1_valid"}, 32'(out1_valid), 32'd0);
        chk({tag, " rst out0_data"},  out0_data,       32'd0);
        chk({tag, " rst out1_data"},  out1_data,       32'd0);
        chk({tag, " rst cnt0"},       32'(cnt0),       32'd0);
        chk({tag, " rst cnt1"},       32'(cnt1),       32'd0);
        chk({tag, " rst in_ready"},   32'(in_ready),   32'd1);
        q0.delete();
        q1.delete();
        mc0 = '0;
        mc1 = '0;
        @(negedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] A1, A2, A3, W3C, B1, B2, B3;
        A1 = 32'hA1A1_A1A1; A2 = 32'hA2A2_A2A2; A3 = 32'hA3A3_A3A3;
        W3C = 32'h3C3C_3C3C;
        B1 = 32'hB1B1_0001; B2 = 32'hB2B2_0002; B3 = 32'hB3B3_0003;

        // reset then idle
        tbl[0]  = mk(0, 0, 0,   0, 0, 1, 0, 0,   0, 0,  0, 0);
        tbl[1]  = mk(0, 1, 0,   0, 0, 1, 0, 0,   0, 0,  0, 0);
        // single word on lane 0, latency 1
        tbl[2]  = mk(1, 0, 1,   1, 0, 1, 0, 0,   0, 0,  0, 0);
        tbl[3]  = mk(0, 0, 0,   1, 0, 1, 1, 1,   0, 0,  0, 0);
        tbl[4]  = mk(0, 0, 0,   1, 0, 1, 0, 0,   0, 0,  1, 0);
        // lane 1 backpressure, lane 0 keeps flowing
        tbl[5]  = mk(1, 1, A1,  1, 0, 1, 0, 0,   0, 0,  1, 0);
        tbl[6]  = mk(1, 1, A2,  1, 0, 1, 0, 0,   1, A1, 1, 0);
        tbl[7]  = mk(1, 1, A3,  1, 0, 0, 0, 0,   1, A1, 1, 0);
        tbl[8]  = mk(1, 0, W3C, 1, 0, 1, 0, 0,   1, A1, 1, 0);
        tbl[9]  = mk(1, 1, A3,  1, 1, 0, 1, W3C, 1, A1, 1, 0);
        tbl[10] = mk(1, 1, A3,  1, 1, 1, 0, 0,   1, A2, 2, 1);
        tbl[11] = mk(0, 1, 0,   1, 1, 1, 0, 0,   1, A3, 2, 2);
        tbl[12] = mk(0, 0, 0,   1, 1, 1, 0, 0,   0, 0,  2, 3);
        // full lane 0 with simultaneous push and pop
        tbl[13] = mk(1, 0, B1,  0, 0, 1, 0, 0,   0, 0,  2, 3);
        tbl[14] = mk(1, 0, B2,  0, 0, 1, 1, B1,  0, 0,  2, 3);
        tbl[15] = mk(1, 0, B3,  1, 0, 0, 1, B1,  0, 0,  2, 3);
        tbl[16] = mk(1, 0, B3,  0, 0, 1, 1, B2,  0, 0,  3, 3);
        tbl[17] = mk(0, 0, 0,   0, 0, 0, 1, B2,  0, 0,  3, 3);
        tbl[18] = mk(0, 0, 0,   1, 0, 0, 1, B2,  0, 0,  3, 3);
        tbl[19] = mk(0, 0, 0,   1, 0, 1, 1, B3,  0, 0,  4, 3);
        tbl[20] = mk(0, 0, 0,   1, 0, 1, 0, 0,   0, 0,  5, 3);

        rst = 1'b1;
        in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
        out0_ready = 1'b0; out1_ready = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;

        for (int i = 0; i < 21; i++) run(tbl[i], 1'b1, $sformatf("row%0d", i));

        // load both lanes, then reset between edges
        run(mk(1, 0, 32'hD0D0_D0D0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, "load0");
        run(mk(1, 1, 32'hD1D1_D1D1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, "load1");
        @(negedge clk);
        #1;
        chk("pre-rst out0_valid", 32'(out0_valid), 32'd1);
        chk("pre-rst out1_valid", 32'(out1_valid), 32'd1);
        async_reset("mid");
        run(mk(1, 0, 32'hC1C1_C1C1, 0, 0, 1, 0, 0, 0, 0, 0, 0), 1'b1, "post-rst push");
        run(mk(0, 0, 0, 0, 0, 1, 1, 32'hC1C1_C1C1, 0, 0, 0, 0), 1'b1, "post-rst lat1");

        // counter wrap: 17 pops on lane 0 with a 4-bit counter
        async_reset("wrap");
        for (int i = 0; i < 17; i++)
            run(mk(1, 0, 32'h1000 + 32'(i), 1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, $sformatf("wrap%0d", i));
        run(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, "drain0");
        run(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, "drain1");
        @(negedge clk);
        #1;
        chk("wrap cnt0", 32'(cnt0), 32'd1);
        chk("wrap cnt1", 32'(cnt1), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
